expr_checker: RTL and testbench
===============================

# expr_checker

Streaming ASCII arithmetic-expression recognizer, the parametrised successor of the single-digit `digit (op digit)*` checker. It consumes one character per accepted cycle and flags, one cycle later, whether the characters since the last restart form a complete well-formed expression. It adds multi-digit numbers, parentheses with bounded nesting, a configurable operator set, an input-valid qualifier, an error pulse and an operator counter. It sits behind the character source (UART/keypad decoder) and feeds the calculator datapath control.

## Interface
- `MAX_DIGITS`, default 4: maximum digits per number literal, range 1..15.
- `MAX_DEPTH`, default 4: maximum parenthesis nesting, range 1..15.
- `OP_MASK`, default 4'b0011: enabled operators. Bit 0 `+` (8'h2B), bit 1 `*` (8'h2A), bit 2 `-` (8'h2D), bit 3 `/` (8'h2F).
- `CNT_W`, default 8: width of the operator counter.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `clr_n` in 1: reset, synchronous and active-low.
- `in` in 8: ASCII character.
- `in_valid` in 1: `in` is consumed on this edge.
- `out` out 1: the expression is complete and balanced.
- `err` out 1: one-cycle pulse when an illegal character is consumed.
- `depth` out 4: current open-parenthesis count.
- `op_cnt` out CNT_W: number of operators accepted since the last restart, saturating.

## Operation
- Character classes:
  - DIGIT: 8'h30..8'h39.
  - OP: any enabled operator in `OP_MASK`. A disabled operator counts as OTHER.
  - LP: 8'h28.
  - RP: 8'h29.
  - OTHER: everything else.
- States:
  - S_IDLE: fresh start.
  - S_OPND: operand expected, after an OP or LP.
  - S_NUM: last character was a digit.
  - S_RPAR: last character was RP.
- Transitions, taken only when `in_valid`=1:
  - S_IDLE or S_OPND:
    - DIGIT → S_NUM, digit count = 1.
    - LP with `depth`<MAX_DEPTH → S_OPND, `depth`+1.
    - Anything else → error.
  - S_NUM:
    - DIGIT with digit count < MAX_DIGITS → S_NUM, count+1. DIGIT at the limit → error.
    - OP → S_OPND, `op_cnt`+1.
    - RP with `depth`>0 → S_RPAR, `depth`−1.
    - Anything else → error.
  - S_RPAR:
    - OP → S_OPND, `op_cnt`+1.
    - RP with `depth`>0 → S_RPAR, `depth`−1.
    - Anything else → error.
- Error handling:
  - Next state is S_IDLE; `depth`, `op_cnt` and the digit count clear; `err`=1 for that cycle only.
  - The offending character is discarded, not re-evaluated as a start. `((1` followed by `x` leaves S_IDLE; a following `5` starts a new expression.
- `out` is registered: `out`=1 exactly when the next state is S_NUM or S_RPAR and the next `depth`==0. Otherwise `out`=0.
- `op_cnt` saturates at 2^CNT_W−1 and never wraps.
- When `in_valid`=0, state, `depth`, `op_cnt`, the digit count and `out` hold; `err`=0.

## Timing
- Reset: when `clr_n`=0 at an edge, it overrides `in_valid`. After that edge `out`=0, `err`=0, `depth`=0, `op_cnt`=0, state is S_IDLE. Asserting reset mid-expression abandons it with no `err` pulse.
- Latency: all outputs reflect character N the cycle after the edge that consumes it. No combinational path from `in` to outputs.
- Throughput: one character per cycle with back-to-back `in_valid`; there is no stall or backpressure.
- Boundary cases:
  - LP at `depth`==MAX_DEPTH → error.
  - RP at `depth`==0 → error.
  - The (MAX_DIGITS+1)th consecutive digit → error.
  - OP in S_IDLE → error, e.g. a leading `+`.
- No unary operators; `-` is binary only.

## Structure
- Package `expr_pkg` holds:
  - ASCII constants: DIGIT_LO/HI, LP, RP, OP_ADD/MUL/SUB/DIV.
  - The OP_MASK bit-position constants.
  - The 2-bit state enum `expr_state_t`.
  - The class enum `chr_class_t` (DIGIT, OP, LP, RP, OTHER).
- Sub-module `expr_char_class` is purely combinational: `in` plus `OP_MASK` produce `chr_class_t`.
- `expr_checker` holds the FSM, depth counter, digit counter, saturating `op_cnt` and output registers.

## Test plan
- Defaults, stream `1`,`2`,`+`,`3`,`*`,`4`,`5` → `out` after each: 1,1,0,1,0,1,1; `op_cnt` ends at 2; `err` never set.
- Stream `(`,`(`,`7`,`)`,`+`,`2`,`)` → `depth` 1,2,2,1,1,1,0; `out` high only after the final `)`.
- MAX_DEPTH=2, stream `(`,`(`,`(` → `err` pulses one cycle after the third char; `depth`=0; a following `9` gives `out`=1.
- Default OP_MASK, stream `8`,`-`,`3` → `err` on `-`; `3` starts fresh, giving `out`=1 and `op_cnt`=0. With OP_MASK=4'b0100, the same stream → `out`=1 and `op_cnt`=1.
- `1`,`2`,`3`,`4`,`5` with MAX_DIGITS=4 → `err` on `5`. Separately, `in_valid`=0 for 3 cycles mid-expression → outputs hold. `clr_n`=0 mid-expression → all outputs 0 the next cycle, with no `err`.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared constants and types for the streaming arithmetic-expression recognizer.
// Character codes, operator-mask bit positions, FSM states and character classes.
package expr_pkg;

  localparam logic [7:0] DIGIT_LO = 8'h30;
  localparam logic [7:0] DIGIT_HI = 8'h39;
  localparam logic [7:0] LP       = 8'h28;
  localparam logic [7:0] RP       = 8'h29;
  localparam logic [7:0] OP_ADD   = 8'h2B;
  localparam logic [7:0] OP_MUL   = 8'h2A;
  localparam logic [7:0] OP_SUB   = 8'h2D;
  localparam logic [7:0] OP_DIV   = 8'h2F;

  localparam int unsigned OP_BIT_ADD = 0;
  localparam int unsigned OP_BIT_MUL = 1;
  localparam int unsigned OP_BIT_SUB = 2;
  localparam int unsigned OP_BIT_DIV = 3;

  typedef enum logic [1:0] {
    StIdle,
    StOpnd,
    StNum,
    StRpar
  } expr_state_t;

  typedef enum logic [2:0] {
    ChrDigit,
    ChrOp,
    ChrLp,
    ChrRp,
    ChrOther
  } chr_class_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= DIGIT_LO) && (c <= DIGIT_HI);
  endfunction

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII character classifier; operators masked off by OP_MASK
// fall through to ChrOther.
module expr_char_class
  import expr_pkg::*;
#(
  parameter logic [3:0] OP_MASK = 4'b0011
) (
  input  logic [7:0] chr_i,
  output chr_class_t cls_o
);

  logic op_hit;

  always_comb begin
    op_hit = ((chr_i == OP_ADD) && OP_MASK[OP_BIT_ADD]) ||
             ((chr_i == OP_MUL) && OP_MASK[OP_BIT_MUL]) ||
             ((chr_i == OP_SUB) && OP_MASK[OP_BIT_SUB]) ||
             ((chr_i == OP_DIV) && OP_MASK[OP_BIT_DIV]);
  end

  always_comb begin
    cls_o = ChrOther;
    if (is_digit(chr_i)) begin
      cls_o = ChrDigit;
    end else if (chr_i == LP) begin
      cls_o = ChrLp;
    end else if (chr_i == RP) begin
      cls_o = ChrRp;
    end else if (op_hit) begin
      cls_o = ChrOp;
    end
  end

endmodule

// File: rtl/expr_checker.sv
// Streaming expression recognizer: one character per valid cycle, registered
// completion flag, error pulse, nesting depth and saturating operator count.
module expr_checker
  import expr_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned MAX_DEPTH  = 4,
  parameter logic [3:0]  OP_MASK    = 4'b0011,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic             err,
  output logic [3:0]       depth,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [3:0]       MaxDigits = 4'(MAX_DIGITS);
  localparam logic [3:0]       MaxDepth  = 4'(MAX_DEPTH);
  localparam logic [CNT_W-1:0] OpCntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] OpCntOne  = CNT_W'(1);

  chr_class_t cls;

  expr_state_t      state_q, state_d;
  logic [3:0]       depth_q, depth_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic             out_q, out_d;
  logic             err_q, err_d;
  logic             fault;

  expr_char_class #(
    .OP_MASK(OP_MASK)
  ) u_char_class (
    .chr_i(in),
    .cls_o(cls)
  );

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    dcnt_d   = dcnt_q;
    op_cnt_d = op_cnt_q;
    err_d    = 1'b0;
    fault    = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StIdle, StOpnd: begin
          if (cls == ChrDigit) begin
            state_d = StNum;
            dcnt_d  = 4'd1;
          end else if ((cls == ChrLp) && (depth_q < MaxDepth)) begin
            state_d = StOpnd;
            depth_d = depth_q + 4'd1;
          end else begin
            fault = 1'b1;
          end
        end
        StNum: begin
          if ((cls == ChrDigit) && (dcnt_q < MaxDigits)) begin
            dcnt_d = dcnt_q + 4'd1;
          end else if (cls == ChrOp) begin
            state_d = StOpnd;
            dcnt_d  = 4'd0;
            if (op_cnt_q != OpCntMax) op_cnt_d = op_cnt_q + OpCntOne;
          end else if ((cls == ChrRp) && (depth_q != 4'd0)) begin
            state_d = StRpar;
            dcnt_d  = 4'd0;
            depth_d = depth_q - 4'd1;
          end else begin
            fault = 1'b1;
          end
        end
        StRpar: begin
          if (cls == ChrOp) begin
            state_d = StOpnd;
            if (op_cnt_q != OpCntMax) op_cnt_d = op_cnt_q + OpCntOne;
          end else if ((cls == ChrRp) && (depth_q != 4'd0)) begin
            depth_d = depth_q - 4'd1;
          end else begin
            fault = 1'b1;
          end
        end
        default: fault = 1'b1;
      endcase

      // The offending character is dropped; the next one starts from idle.
      if (fault) begin
        state_d  = StIdle;
        depth_d  = 4'd0;
        dcnt_d   = 4'd0;
        op_cnt_d = '0;
        err_d    = 1'b1;
      end
    end

    out_d = ((state_d == StNum) || (state_d == StRpar)) && (depth_d == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= StIdle;
      depth_q  <= 4'd0;
      dcnt_q   <= 4'd0;
      op_cnt_q <= '0;
      out_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      dcnt_q   <= dcnt_d;
      op_cnt_q <= op_cnt_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign out    = out_q;
  assign err    = err_q;
  assign depth  = depth_q;
  assign op_cnt = op_cnt_q;

endmodule

// File: tb/tb_expr_checker.sv
// Directed bench: three configurations share one character stream; each step
// checks hand-computed outputs with immediate assertions.
module tb_expr_checker;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;

  logic       out0, err0, out1, err1, out2, err2;
  logic [3:0] depth0, depth1, depth2;
  logic [7:0] opc0, opc2;
  logic [1:0] opc1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  expr_checker u_def (
    .clk(clk), .clr_n(clr_n), .in(in), .in_valid(in_valid),
    .out(out0), .err(err0), .depth(depth0), .op_cnt(opc0)
  );

  expr_checker #(
    .MAX_DEPTH(2), .CNT_W(2)
  ) u_dep2 (
    .clk(clk), .clr_n(clr_n), .in(in), .in_valid(in_valid),
    .out(out1), .err(err1), .depth(depth1), .op_cnt(opc1)
  );

  expr_checker #(
    .OP_MASK(4'b0100)
  ) u_sub (
    .clk(clk), .clr_n(clr_n), .in(in), .in_valid(in_valid),
    .out(out2), .err(err2), .depth(depth2), .op_cnt(opc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    in = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    in = "x";
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    string s;
    int exp_out[7];
    int exp_dep[7];

    // Reset held with valid illegal characters: must not pulse err.
    do_reset();
    do_reset();
    chk("rst_out", 32'(out0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_depth", 32'(depth0), 0);
    chk("rst_opcnt", 32'(opc0), 0);

    // Multi-digit numbers and operators.
    s = "12+3*45";
    exp_out = '{1, 1, 0, 1, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      send(s[i]);
      chk($sformatf("t1_out[%0d]", i), 32'(out0), 32'(exp_out[i]));
      chk($sformatf("t1_err[%0d]", i), 32'(err0), 0);
    end
    chk("t1_opcnt", 32'(opc0), 2);

    // Nested parentheses.
    do_reset();
    s = "((7)+2)";
    exp_dep = '{1, 2, 2, 1, 1, 1, 0};
    exp_out = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      send(s[i]);
      chk($sformatf("t2_depth[%0d]", i), 32'(depth0), 32'(exp_dep[i]));
      chk($sformatf("t2_out[%0d]", i), 32'(out0), 32'(exp_out[i]));
    end
    chk("t2_opcnt", 32'(opc0), 1);

    // Depth limit on the MAX_DEPTH=2 instance.
    do_reset();
    send("(");
    chk("t3_d1", 32'(depth1), 1);
    send("(");
    chk("t3_d2", 32'(depth1), 2);
    chk("t3_err_before", 32'(err1), 0);
    send("(");
    chk("t3_err", 32'(err1), 1);
    chk("t3_depth_clr", 32'(depth1), 0);
    chk("t3_def_depth", 32'(depth0), 3);
    chk("t3_def_err", 32'(err0), 0);
    send("9");
    chk("t3_out9", 32'(out1), 1);
    chk("t3_err_pulse", 32'(err1), 0);
    chk("t3_def_out9", 32'(out0), 0);

    // Operator counter saturation with CNT_W=2.
    do_reset();
    s = "1+1+1+1+1";
    for (int i = 0; i < 9; i++) send(s[i]);
    chk("t_sat_opc1", 32'(opc1), 3);
    chk("t_sat_opc0", 32'(opc0), 4);
    chk("t_sat_out1", 32'(out1), 1);

    // Disabled vs enabled '-'.
    do_reset();
    send("8");
    chk("t4_out8", 32'(out0), 1);
    send("-");
    chk("t4_err_def", 32'(err0), 1);
    chk("t4_out_def", 32'(out0), 0);
    chk("t4_err_sub", 32'(err2), 0);
    chk("t4_opc_sub_mid", 32'(opc2), 1);
    send("3");
    chk("t4_out3_def", 32'(out0), 1);
    chk("t4_opc_def", 32'(opc0), 0);
    chk("t4_err3_def", 32'(err0), 0);
    chk("t4_out3_sub", 32'(out2), 1);
    chk("t4_opc_sub", 32'(opc2), 1);

    // Digit-count limit.
    do_reset();
    s = "1234";
    for (int i = 0; i < 4; i++) send(s[i]);
    chk("t5_out4", 32'(out0), 1);
    chk("t5_err4", 32'(err0), 0);
    send("5");
    chk("t5_err5", 32'(err0), 1);
    chk("t5_out5", 32'(out0), 0);
    send("6");
    chk("t5_out6", 32'(out0), 1);

    // RP at depth 0, leading operator.
    do_reset();
    send(")");
    chk("t6_rp_err", 32'(err0), 1);
    send("+");
    chk("t6_op_err", 32'(err0), 1);
    idle(1);
    chk("t6_err_drop", 32'(err0), 0);

    // in_valid low holds everything.
    do_reset();
    s = "(1+2)*3";
    for (int i = 0; i < 7; i++) send(s[i]);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk($sformatf("t7_hold_out[%0d]", i), 32'(out0), 1);
      chk($sformatf("t7_hold_opc[%0d]", i), 32'(opc0), 2);
      chk($sformatf("t7_hold_err[%0d]", i), 32'(err0), 0);
    end
    send("+");
    chk("t7_after_opc", 32'(opc0), 3);
    chk("t7_after_out", 32'(out0), 0);

    // Reset mid-expression abandons it silently.
    do_reset();
    s = "(1+";
    for (int i = 0; i < 3; i++) send(s[i]);
    chk("t8_pre_depth", 32'(depth0), 1);
    do_reset();
    chk("t8_out", 32'(out0), 0);
    chk("t8_err", 32'(err0), 0);
    chk("t8_depth", 32'(depth0), 0);
    chk("t8_opc", 32'(opc0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
